// File: rtl/control_sequencer.sv
// SAP-1 controller/sequencer: six-state T-state ring with opcode decode driving
// the program counter, MAR, RAM, IR, A/B, ALU and output-register control lines.
module control_sequencer #(
   parameter int OPCODE_W = 4,
   parameter int NUM_T    = 6
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                run,
   input  logic                step_mode,
   input  logic                step,
   input  logic [OPCODE_W-1:0] opcode,
   output logic [NUM_T-1:0]    t_state,
   output logic                pc_inc,
   output logic                pc_out,
   output logic                jump,
   output logic                mar_in,
   output logic                ram_out,
   output logic                ir_in,
   output logic                ir_out,
   output logic                a_in,
   output logic                a_out,
   output logic                b_in,
   output logic                alu_out,
   output logic                sub,
   output logic                out_in,
   output logic                halt
);

   typedef enum logic [2:0] {
      S_IDLE, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
   } state_t;

   localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(4'b0000);
   localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(4'b0001);
   localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(4'b0010);
   localparam logic [OPCODE_W-1:0] OP_JMP = OPCODE_W'(4'b0011);
   localparam logic [OPCODE_W-1:0] OP_OUT = OPCODE_W'(4'b1110);
   localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(4'b1111);

   state_t state;
   logic   step_q;
   logic   adv;

   // In step mode only the rising edge of the button advances; holding it counts once.
   assign adv = step_mode ? (step & ~step_q) : 1'b1;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state  <= S_IDLE;
         step_q <= 1'b0;
      end else begin
         step_q <= step;
         case (state)
            S_IDLE: if (run) state <= S_T1;
            S_T1:   if (adv) state <= S_T2;
            S_T2:   if (adv) state <= S_T3;
            S_T3:   if (adv) state <= S_T4;
            S_T4:   if (adv) state <= (opcode == OP_HLT) ? S_HALT : S_T5;
            S_T5:   if (adv) state <= S_T6;
            S_T6:   if (adv) state <= S_T1;
            S_HALT: state <= S_HALT;
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      t_state = '0;
      case (state)
         S_T1: t_state[0] = 1'b1;
         S_T2: t_state[1] = 1'b1;
         S_T3: t_state[2] = 1'b1;
         S_T4: t_state[3] = 1'b1;
         S_T5: t_state[4] = 1'b1;
         S_T6: t_state[5] = 1'b1;
         default: t_state = '0;
      endcase
   end

   // Controls fire only on the advancing clock, so a stalled step cycle is quiet.
   always_comb begin
      pc_inc  = 1'b0;
      pc_out  = 1'b0;
      jump    = 1'b0;
      mar_in  = 1'b0;
      ram_out = 1'b0;
      ir_in   = 1'b0;
      ir_out  = 1'b0;
      a_in    = 1'b0;
      a_out   = 1'b0;
      b_in    = 1'b0;
      alu_out = 1'b0;
      sub     = 1'b0;
      out_in  = 1'b0;
      halt    = (state == S_HALT);
      if (adv) begin
         case (state)
            S_T1: begin pc_out = 1'b1; mar_in = 1'b1; end
            S_T2: pc_inc = 1'b1;
            S_T3: begin ram_out = 1'b1; ir_in = 1'b1; end
            S_T4: begin
               if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB) begin
                  ir_out = 1'b1; mar_in = 1'b1;
               end else if (opcode == OP_JMP) begin
                  ir_out = 1'b1; jump = 1'b1;
               end else if (opcode == OP_OUT) begin
                  a_out = 1'b1; out_in = 1'b1;
               end else if (opcode == OP_HLT) begin
                  halt = 1'b1;
               end
            end
            S_T5: begin
               if (opcode == OP_LDA) begin
                  ram_out = 1'b1; a_in = 1'b1;
               end else if (opcode == OP_ADD || opcode == OP_SUB) begin
                  ram_out = 1'b1; b_in = 1'b1; sub = (opcode == OP_SUB);
               end
            end
            S_T6: begin
               if (opcode == OP_ADD || opcode == OP_SUB) begin
                  alu_out = 1'b1; a_in = 1'b1; sub = (opcode == OP_SUB);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: expected control vectors are queued as
// each cycle's stimulus is applied and compared against the outputs mid-cycle.
module tb_control_sequencer;

   logic       clock;
   logic       reset;
   logic       run;
   logic       step_mode;
   logic       step;
   logic [3:0] opcode;
   logic [5:0] t_state;
   logic pc_inc, pc_out, jump, mar_in, ram_out, ir_in, ir_out;
   logic a_in, a_out, b_in, alu_out, sub, out_in, halt;

   localparam logic [13:0] PC_INC  = 14'h2000;
   localparam logic [13:0] PC_OUT  = 14'h1000;
   localparam logic [13:0] JUMP    = 14'h0800;
   localparam logic [13:0] MAR_IN  = 14'h0400;
   localparam logic [13:0] RAM_OUT = 14'h0200;
   localparam logic [13:0] IR_IN   = 14'h0100;
   localparam logic [13:0] IR_OUT  = 14'h0080;
   localparam logic [13:0] A_IN    = 14'h0040;
   localparam logic [13:0] A_OUT   = 14'h0020;
   localparam logic [13:0] B_IN    = 14'h0010;
   localparam logic [13:0] ALU_OUT = 14'h0008;
   localparam logic [13:0] SUB     = 14'h0004;
   localparam logic [13:0] OUT_IN  = 14'h0002;
   localparam logic [13:0] HALT    = 14'h0001;
   localparam logic [13:0] NONE    = 14'h0000;
   localparam logic [13:0] FETCH1  = 14'h1400;
   localparam logic [13:0] FETCH3  = 14'h0300;

   logic [19:0] obs;
   logic [19:0] e;
   logic [19:0] sb [$];
   int n_checks;
   int n_fail;

   assign obs = {t_state, pc_inc, pc_out, jump, mar_in, ram_out, ir_in, ir_out,
                 a_in, a_out, b_in, alu_out, sub, out_in, halt};

   control_sequencer #(.OPCODE_W(4), .NUM_T(6)) dut (
      .clock(clock), .reset(reset), .run(run), .step_mode(step_mode), .step(step),
      .opcode(opcode), .t_state(t_state), .pc_inc(pc_inc), .pc_out(pc_out),
      .jump(jump), .mar_in(mar_in), .ram_out(ram_out), .ir_in(ir_in),
      .ir_out(ir_out), .a_in(a_in), .a_out(a_out), .b_in(b_in),
      .alu_out(alu_out), .sub(sub), .out_in(out_in), .halt(halt)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // k = 1..6 selects T1..T6; 0 means no T-state (IDLE or HALT)
   function automatic logic [19:0] vec(input int k, input logic [13:0] c);
      logic [5:0] t;
      t = (k == 0) ? 6'b0 : (6'b000001 << (k - 1));
      return {t, c};
   endfunction

   task automatic start(input logic [3:0] op);
      opcode = op;
      reset  = 1'b0;
      #2;
      reset  = 1'b1;
      run    = 1'b1;
      @(posedge clock);
      #1;
      run    = 1'b0;
   endtask

   always @(negedge clock) begin
      if (reset === 1'b1) begin
         n_checks++;
         if (!$onehot0({pc_out, ram_out, ir_out, a_out, alu_out}) || (pc_inc && jump)) begin
            n_fail++;
            $display("FAIL invariant: drivers=%b pc_inc=%b jump=%b, required at most one driver and not both pc_inc/jump",
                     {pc_out, ram_out, ir_out, a_out, alu_out}, pc_inc, jump);
         end
      end
   end

   task automatic test_reset();
      reset = 1'b0; run = 1'b0; step_mode = 1'b0; step = 1'b0; opcode = 4'h0;
      for (int i = 0; i < 2; i++) begin
         sb.push_back(vec(0, NONE));
         @(negedge clock);
         e = sb.pop_front(); n_checks++;
         if (obs !== e) begin n_fail++; $display("FAIL reset_low cycle %0d: got %h expected %h", i, obs, e); end
      end
      reset = 1'b1;
      sb.push_back(vec(0, NONE));
      @(posedge clock); #1;
      @(negedge clock);
      e = sb.pop_front(); n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL idle_no_run: got %h expected %h", obs, e); end
      run = 1'b1;
      @(posedge clock); #1;
      run = 1'b0;
      sb.push_back(vec(1, FETCH1));
      @(negedge clock);
      e = sb.pop_front(); n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL run_to_t1: got %h expected %h", obs, e); end
   endtask

   task automatic test_add();
      logic [19:0] ex [7];
      step_mode = 1'b0;
      ex = '{vec(1, FETCH1), vec(2, PC_INC), vec(3, FETCH3), vec(4, IR_OUT | MAR_IN),
             vec(5, RAM_OUT | B_IN), vec(6, ALU_OUT | A_IN), vec(1, FETCH1)};
      start(4'b0001);
      for (int i = 0; i < 7; i++) begin
         sb.push_back(ex[i]);
         @(negedge clock);
         e = sb.pop_front(); n_checks++;
         if (obs !== e) begin n_fail++; $display("FAIL add cycle %0d: got %h expected %h", i, obs, e); end
         @(posedge clock); #1;
      end
   endtask

   task automatic test_jmp();
      logic [19:0] ex [7];
      step_mode = 1'b0;
      ex = '{vec(1, FETCH1), vec(2, PC_INC), vec(3, FETCH3), vec(4, IR_OUT | JUMP),
             vec(5, NONE), vec(6, NONE), vec(1, FETCH1)};
      start(4'b0011);
      for (int i = 0; i < 7; i++) begin
         sb.push_back(ex[i]);
         @(negedge clock);
         e = sb.pop_front(); n_checks++;
         if (obs !== e) begin n_fail++; $display("FAIL jmp cycle %0d: got %h expected %h", i, obs, e); end
         @(posedge clock); #1;
      end
   endtask

   task automatic test_halt();
      logic [19:0] ex [8];
      step_mode = 1'b0;
      ex = '{vec(1, FETCH1), vec(2, PC_INC), vec(3, FETCH3), vec(4, HALT),
             vec(0, HALT), vec(0, HALT), vec(0, HALT), vec(0, HALT)};
      start(4'b1111);
      for (int i = 0; i < 8; i++) begin
         if (i == 5) step_mode = 1'b1;
         sb.push_back(ex[i]);
         @(negedge clock);
         e = sb.pop_front(); n_checks++;
         if (obs !== e) begin n_fail++; $display("FAIL hlt cycle %0d: got %h expected %h", i, obs, e); end
         @(posedge clock); #1;
      end
      step_mode = 1'b0;
      #2;
      reset = 1'b0;
      sb.push_back(vec(0, NONE));
      #1;
      e = sb.pop_front(); n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL hlt_reset_async: got %h expected %h", obs, e); end
      reset = 1'b1;
   endtask

   task automatic test_step();
      logic [19:0] ex [15];
      logic        st [15];
      step_mode = 1'b1;
      step      = 1'b0;
      ex = '{vec(1, NONE), vec(1, FETCH1), vec(2, NONE), vec(2, PC_INC), vec(3, NONE),
             vec(3, NONE), vec(3, NONE), vec(3, NONE), vec(3, NONE), vec(3, FETCH3),
             vec(4, NONE), vec(4, IR_OUT | MAR_IN), vec(5, RAM_OUT | A_IN), vec(6, NONE),
             vec(1, FETCH1)};
      st = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1,
             1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      start(4'b0000);
      for (int i = 0; i < 15; i++) begin
         step      = st[i];
         step_mode = (i < 11);
         sb.push_back(ex[i]);
         @(negedge clock);
         e = sb.pop_front(); n_checks++;
         if (obs !== e) begin n_fail++; $display("FAIL step cycle %0d: got %h expected %h", i, obs, e); end
         @(posedge clock); #1;
      end
      step_mode = 1'b0;
      step      = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [19:0] ex [13];
      step_mode = 1'b0;
      ex = '{vec(1, FETCH1), vec(2, PC_INC), vec(3, FETCH3), vec(4, A_OUT | OUT_IN),
             vec(5, NONE), vec(6, NONE),
             vec(1, FETCH1), vec(2, PC_INC), vec(3, FETCH3), vec(4, NONE),
             vec(5, NONE), vec(6, NONE), vec(1, FETCH1)};
      start(4'b1110);
      for (int i = 0; i < 13; i++) begin
         opcode = (i < 6) ? 4'b1110 : 4'b0101;
         sb.push_back(ex[i]);
         @(negedge clock);
         e = sb.pop_front(); n_checks++;
         if (obs !== e) begin n_fail++; $display("FAIL b2b cycle %0d: got %h expected %h", i, obs, e); end
         @(posedge clock); #1;
      end
   endtask

   task automatic test_reset_mid();
      logic [19:0] ex [10];
      logic [19:0] rf [3];
      step_mode = 1'b0;
      ex = '{vec(1, FETCH1), vec(2, PC_INC), vec(3, FETCH3), vec(4, IR_OUT | MAR_IN),
             vec(5, RAM_OUT | B_IN | SUB), vec(6, ALU_OUT | A_IN | SUB),
             vec(1, FETCH1), vec(2, PC_INC), vec(3, FETCH3), vec(4, IR_OUT | MAR_IN)};
      rf = '{vec(1, FETCH1), vec(2, PC_INC), vec(3, FETCH3)};
      start(4'b0010);
      for (int i = 0; i < 10; i++) begin
         sb.push_back(ex[i]);
         @(negedge clock);
         e = sb.pop_front(); n_checks++;
         if (obs !== e) begin n_fail++; $display("FAIL sub cycle %0d: got %h expected %h", i, obs, e); end
         @(posedge clock); #1;
      end
      sb.push_back(vec(5, RAM_OUT | B_IN | SUB));
      @(negedge clock);
      e = sb.pop_front(); n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL sub_t5: got %h expected %h", obs, e); end
      #2;
      reset = 1'b0;
      sb.push_back(vec(0, NONE));
      #1;
      e = sb.pop_front(); n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL mid_reset_async: got %h expected %h", obs, e); end
      #1;
      reset = 1'b1;
      run   = 1'b1;
      @(posedge clock); #1;
      run = 1'b0;
      for (int i = 0; i < 3; i++) begin
         sb.push_back(rf[i]);
         @(negedge clock);
         e = sb.pop_front(); n_checks++;
         if (obs !== e) begin n_fail++; $display("FAIL restart cycle %0d: got %h expected %h", i, obs, e); end
         @(posedge clock); #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required normal completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_add();
      test_jmp();
      test_halt();
      test_step();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
